// File: rtl/mac_sequencer_pkg.sv
// Shared constants and state encoding for the MAC job sequencer.
package mac_pkg;

  localparam int unsigned NUM_LANES = 16;
  localparam int unsigned DEPTH     = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned RES_W     = 4;
  localparam int unsigned DRAIN_CYC = 3;
  localparam int unsigned OUT_LAT   = 2;
  localparam int unsigned WAIT_W    = 2;
  localparam int unsigned STATE_W   = 4;

  localparam logic [3:0] ST_IDLE            = 4'd0;
  localparam logic [3:0] ST_CLEAR           = 4'd1;
  localparam logic [3:0] ST_LOAD            = 4'd2;
  localparam logic [3:0] ST_COMPUTE         = 4'd3;
  localparam logic [3:0] ST_DRAIN           = 4'd4;
  localparam logic [3:0] ST_READOUT_ISSUE   = 4'd5;
  localparam logic [3:0] ST_READOUT_WAIT    = 4'd6;
  localparam logic [3:0] ST_READOUT_PRESENT = 4'd7;
  localparam logic [3:0] ST_FIN             = 4'd8;

endpackage

// File: rtl/mac_sequencer_if.sv
// Weight/activation source and result sink handshakes of the MAC sequencer.
interface mac_sequencer_if;
  import mac_pkg::*;

  logic             wValid;
  logic             wReady;
  logic             dValid;
  logic             dReady;
  logic             resValid;
  logic             resReady;
  logic [RES_W-1:0] resIdx;

  modport master (output wValid, dValid, resReady,
                  input  wReady, dReady, resValid, resIdx);
  modport slave  (input  wValid, dValid, resReady,
                  output wReady, dReady, resValid, resIdx);
endinterface

// File: rtl/mac_sequencer_strobe_align.sv
// One-cycle register stage aligning core write/new-data strobes after their address.
module strobe_align (
  input  logic clk,
  input  logic rst_n,
  input  logic i_we,
  input  logic i_newdata,
  output logic o_we,
  output logic o_newdata
);

  logic r_we;
  logic r_newdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_newdata <= 1'b0;
    end else begin
      r_we      <= i_we;
      r_newdata <= i_newdata;
    end
  end

  assign o_we      = r_we;
  assign o_newdata = r_newdata;

endmodule

// File: rtl/mac_sequencer.sv
// Job controller for the 16-lane weight-stationary MAC core.
// Optional MAC_SEQ_PERF_EN adds a saturating stallCnt output.
module mac_sequencer
  import mac_pkg::*;
(
  input  logic                 Clk,
  input  logic                 resetN,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    kernelLen,
  mac_sequencer_if.slave       bus,
  output logic                 busy,
  output logic                 done,
  output logic                 macWE,
  output logic                 macNEWDATA,
  output logic                 macCOMP,
  output logic [ADDR_W-1:0]    macAddrWeight,
  output logic [NUM_LANES-1:0] macAddrEn,
  output logic [RES_W-1:0]     macAddrResult,
  output logic [NUM_LANES-1:0] macReset
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [15:0]          stallCnt
`endif
);

  logic [STATE_W-1:0] r_state, w_state_n;
  logic [ADDR_W-1:0]  r_klen, w_klen_n;
  logic [ADDR_W-1:0]  r_tap, w_tap_n;
  logic [RES_W-1:0]   r_lane, w_lane_n;
  logic [WAIT_W-1:0]  r_wait, w_wait_n;
  logic [RES_W-1:0]   r_addr_res, w_addr_res_n;
  logic [RES_W-1:0]   r_res_idx, w_res_idx_n;
  logic r_busy, r_done, r_wready, r_dready, r_res_valid, r_comp;
  logic [NUM_LANES-1:0] r_addr_en, r_mac_reset;
  logic w_we_c, w_nd_c, w_last_tap;

  // Tap never runs past the last weight register, whatever kernelLen says.
  assign w_last_tap = (r_tap == r_klen) || (r_tap == ADDR_W'(DEPTH - 1));

  always_comb begin
    w_state_n = r_state;
    w_klen_n  = r_klen;
    w_tap_n   = r_tap;
    w_lane_n  = r_lane;
    w_wait_n  = r_wait;
    w_we_c    = 1'b0;
    w_nd_c    = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_klen_n  = kernelLen;
        w_state_n = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_tap_n   = '0;
        w_state_n = ST_LOAD;
      end
      ST_LOAD: if (r_wready && bus.wValid) begin
        w_we_c = 1'b1;
        if (w_last_tap) begin
          w_tap_n   = '0;
          w_state_n = ST_COMPUTE;
        end else begin
          w_tap_n = r_tap + ADDR_W'(1);
        end
      end
      ST_COMPUTE: if (r_dready && bus.dValid) begin
        w_nd_c = 1'b1;
        if (w_last_tap) begin
          w_tap_n   = '0;
          w_wait_n  = '0;
          w_state_n = ST_DRAIN;
        end else begin
          w_tap_n = r_tap + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (r_wait == WAIT_W'(DRAIN_CYC - 1)) begin
          w_wait_n  = '0;
          w_lane_n  = '0;
          w_state_n = ST_READOUT_ISSUE;
        end else begin
          w_wait_n = r_wait + WAIT_W'(1);
        end
      end
      ST_READOUT_ISSUE: begin
        w_wait_n  = '0;
        w_state_n = ST_READOUT_WAIT;
      end
      ST_READOUT_WAIT: begin
        if (r_wait == WAIT_W'(OUT_LAT - 1)) begin
          w_wait_n  = '0;
          w_state_n = ST_READOUT_PRESENT;
        end else begin
          w_wait_n = r_wait + WAIT_W'(1);
        end
      end
      ST_READOUT_PRESENT: if (r_res_valid && bus.resReady) begin
        if (r_lane == RES_W'(NUM_LANES - 1)) begin
          w_lane_n  = '0;
          w_state_n = ST_FIN;
        end else begin
          w_lane_n  = r_lane + RES_W'(1);
          w_state_n = ST_READOUT_ISSUE;
        end
      end
      ST_FIN:  w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
    // macAddrResult only moves when a capture is issued.
    w_addr_res_n = (w_state_n == ST_READOUT_ISSUE) ? w_lane_n : r_addr_res;
    w_res_idx_n  = (w_state_n == ST_READOUT_PRESENT) ? w_lane_n : '0;
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge Clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_klen      <= '0;
      r_tap       <= '0;
      r_lane      <= '0;
      r_wait      <= '0;
      r_addr_res  <= '0;
      r_res_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wready    <= 1'b0;
      r_dready    <= 1'b0;
      r_res_valid <= 1'b0;
      r_comp      <= 1'b0;
      r_addr_en   <= '0;
      r_mac_reset <= '0;
    end else begin
      r_state     <= w_state_n;
      r_klen      <= w_klen_n;
      r_tap       <= w_tap_n;
      r_lane      <= w_lane_n;
      r_wait      <= w_wait_n;
      r_addr_res  <= w_addr_res_n;
      r_res_idx   <= w_res_idx_n;
      r_busy      <= (w_state_n != ST_IDLE);
      r_done      <= (w_state_n == ST_FIN);
      r_wready    <= (w_state_n == ST_LOAD);
      r_dready    <= (w_state_n == ST_COMPUTE);
      r_res_valid <= (w_state_n == ST_READOUT_PRESENT);
      r_comp      <= (w_state_n == ST_READOUT_ISSUE);
      r_addr_en   <= ((w_state_n == ST_COMPUTE) || (w_state_n == ST_DRAIN)) ? '1 : '0;
      r_mac_reset <= (w_state_n == ST_CLEAR) ? '1 : '0;
    end
  end

  strobe_align u_strobe_align (
    .clk      (Clk),
    .rst_n    (resetN),
    .i_we     (w_we_c),
    .i_newdata(w_nd_c),
    .o_we     (macWE),
    .o_newdata(macNEWDATA)
  );

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] r_stall_cnt, w_stall_cnt_n;

  // Counts starved LOAD/COMPUTE cycles for the current job.
  always_comb begin
    w_stall_cnt_n = r_stall_cnt;
    if ((r_state == ST_IDLE) && start) begin
      w_stall_cnt_n = '0;
    end else if ((((r_state == ST_LOAD) && !bus.wValid) ||
                  ((r_state == ST_COMPUTE) && !bus.dValid)) &&
                 (r_stall_cnt != 16'hFFFF)) begin
      w_stall_cnt_n = r_stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge resetN) begin
    if (!resetN) r_stall_cnt <= '0;
    else         r_stall_cnt <= w_stall_cnt_n;
  end

  assign stallCnt = r_stall_cnt;
`endif

  assign busy          = r_busy;
  assign done          = r_done;
  assign macCOMP       = r_comp;
  assign macAddrWeight = r_tap;
  assign macAddrEn     = r_addr_en;
  assign macAddrResult = r_addr_res;
  assign macReset      = r_mac_reset;
  assign bus.wReady    = r_wready;
  assign bus.dReady    = r_dready;
  assign bus.resValid  = r_res_valid;
  assign bus.resIdx    = r_res_idx;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized job-level bench for mac_sequencer with an event-level expectation model.
module tb_mac_sequencer;
  import mac_pkg::*;

  logic                 Clk = 1'b0;
  logic                 resetN = 1'b0;
  logic                 start = 1'b0;
  logic [ADDR_W-1:0]    kernelLen = '0;
  logic                 busy, done, macWE, macNEWDATA, macCOMP;
  logic [ADDR_W-1:0]    macAddrWeight;
  logic [NUM_LANES-1:0] macAddrEn, macReset;
  logic [RES_W-1:0]     macAddrResult;
`ifdef MAC_SEQ_PERF_EN
  logic [15:0]          stallCnt;
`endif

  mac_sequencer_if bus ();

  mac_sequencer dut (
    .Clk          (Clk),
    .resetN       (resetN),
    .start        (start),
    .kernelLen    (kernelLen),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .macWE        (macWE),
    .macNEWDATA   (macNEWDATA),
    .macCOMP      (macCOMP),
    .macAddrWeight(macAddrWeight),
    .macAddrEn    (macAddrEn),
    .macAddrResult(macAddrResult),
    .macReset     (macReset)
`ifdef MAC_SEQ_PERF_EN
    ,
    .stallCnt     (stallCnt)
`endif
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({busy, done, macWE, macNEWDATA, macCOMP, macAddrWeight, macAddrEn,
                macAddrResult, macReset, bus.wReady, bus.dReady, bus.resValid, bus.resIdx});
  endfunction

  // One job; forced stalls are applied before the given beat index (-1 = none).
  task automatic run_job(input int klen, input int wmax, input int dmax,
                         input int wf_beat, input int wf_len,
                         input int df_beat, input int df_len,
                         input int hold_lane, input int hold_len, input int abort_lane);
    int wq[$], dq[$], rq[$], cq[$];
    int cyc = 0, reset_cnt = 0, we_bad = 0, nd_bad = 0, en_ffff = 0, en_bad = 0;
    int comp_cnt = 0, comp_present = 0, lat_bad = 0, busy_cyc = 0;
    int ws_tot = 0, ds_tot = 0, last_d_cyc = -100, first_comp_cyc = -1, last_comp_cyc = -100;
    int wbeat = 0, dbeat = 0, hold_left = hold_len, bad = 0, exp_busy, seen_done, seen_busy;
    int wstall_left, dstall_left;
    bit prev_wacc = 0, prev_dacc = 0, prev_rv = 0, finished = 0, aborted = 0;
    logic [15:0] stall_at_done = '0;

    wstall_left = (wf_beat == 0) ? wf_len : $urandom_range(0, wmax);
    dstall_left = (df_beat == 0) ? df_len : $urandom_range(0, dmax);
    @(negedge Clk);
    start = 1'b1;
    kernelLen = ADDR_W'(klen);
    while (!finished && !aborted && cyc < 3000) begin
      @(negedge Clk);
      if (cyc == 0) check("clear_first_cycle", 64'(macReset), 64'(16'hFFFF));
      if (macReset == '1) reset_cnt++;
      if (busy) busy_cyc++;
      if (macWE !== prev_wacc) we_bad++;
      if (macNEWDATA !== prev_dacc) nd_bad++;
      if (macAddrEn == '1) en_ffff++;
      else if (macAddrEn != '0) en_bad++;
      if (macCOMP) begin
        comp_cnt++;
        cq.push_back(int'(macAddrResult));
        last_comp_cyc = cyc;
        if (first_comp_cyc < 0) first_comp_cyc = cyc;
      end
      if (macCOMP && bus.resValid) comp_present++;
      if (bus.resValid && !prev_rv && (cyc - last_comp_cyc != int'(OUT_LAT) + 1)) lat_bad++;
      if (done) begin
        finished = 1;
`ifdef MAC_SEQ_PERF_EN
        stall_at_done = stallCnt;
`endif
      end
      if (abort_lane >= 0 && bus.resValid && int'(bus.resIdx) == abort_lane) begin
        resetN = 1'b0;
        #1;
        check("abort_outputs_zero", all_outputs(), 64'd0);
        aborted = 1;
      end else begin
        start = (busy && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
        kernelLen = ADDR_W'($urandom);
        if (bus.wReady) begin
          if (wstall_left > 0) begin
            bus.wValid = 1'b0; wstall_left--; ws_tot++;
          end else begin
            bus.wValid = 1'b1; wq.push_back(int'(macAddrWeight)); wbeat++;
            wstall_left = (wbeat == wf_beat) ? wf_len : $urandom_range(0, wmax);
          end
          prev_wacc = bus.wValid;
        end else begin
          bus.wValid = 1'($urandom_range(0, 1)); prev_wacc = 0;
        end
        if (bus.dReady) begin
          if (dstall_left > 0) begin
            bus.dValid = 1'b0; dstall_left--; ds_tot++;
          end else begin
            bus.dValid = 1'b1; dq.push_back(int'(macAddrWeight)); dbeat++; last_d_cyc = cyc;
            dstall_left = (dbeat == df_beat) ? df_len : $urandom_range(0, dmax);
          end
          prev_dacc = bus.dValid;
        end else begin
          bus.dValid = 1'($urandom_range(0, 1)); prev_dacc = 0;
        end
        if (bus.resValid) begin
          if (int'(bus.resIdx) == hold_lane && hold_left > 0) begin
            bus.resReady = 1'b0; hold_left--;
          end else begin
            bus.resReady = 1'b1; rq.push_back(int'(bus.resIdx));
          end
        end else begin
          bus.resReady = 1'($urandom_range(0, 1));
        end
        prev_rv = bus.resValid;
      end
      cyc++;
    end

    if (aborted) begin
      start = 1'b0; bus.wValid = 1'b0; bus.dValid = 1'b0; bus.resReady = 1'b0;
      repeat (2) @(negedge Clk);
      check("abort_held_zero", all_outputs(), 64'd0);
      resetN = 1'b1;
      seen_done = 0; seen_busy = 0;
      repeat (6) begin
        @(negedge Clk);
        if (done) seen_done++;
        if (busy) seen_busy++;
      end
      check("abort_no_done", 64'(seen_done), 64'd0);
      check("abort_idle", 64'(seen_busy), 64'd0);
      return;
    end

    check("job_done", 64'(finished), 64'd1);
    check("reset_pulse_count", 64'(reset_cnt), 64'd1);
    check("weight_beats", 64'(wq.size()), 64'(klen + 1));
    check("data_beats", 64'(dq.size()), 64'(klen + 1));
    bad = 0;
    foreach (wq[i]) if (wq[i] != i) bad++;
    foreach (dq[i]) if (dq[i] != i) bad++;
    check("tap_sequence", 64'(bad), 64'd0);
    check("we_align", 64'(we_bad), 64'd0);
    check("newdata_align", 64'(nd_bad), 64'd0);
    check("addr_en_cycles", 64'(en_ffff), 64'(klen + 1 + ds_tot + int'(DRAIN_CYC)));
    check("addr_en_values", 64'(en_bad), 64'd0);
    check("drain_gap", 64'(first_comp_cyc - last_d_cyc), 64'(DRAIN_CYC + 1));
    check("comp_count", 64'(comp_cnt), 64'(NUM_LANES));
    check("result_count", 64'(rq.size()), 64'(NUM_LANES));
    bad = 0;
    foreach (rq[i]) if (rq[i] != i) bad++;
    foreach (cq[i]) if (cq[i] != i) bad++;
    check("lane_order", 64'(bad), 64'd0);
    check("comp_while_present", 64'(comp_present), 64'd0);
    check("out_latency", 64'(lat_bad), 64'd0);
    exp_busy = 1 + 2 * (klen + 1) + ws_tot + ds_tot + int'(DRAIN_CYC)
             + int'(NUM_LANES) * (2 + int'(OUT_LAT)) + (hold_lane >= 0 ? hold_len : 0) + 1;
    check("busy_cycles", 64'(busy_cyc), 64'(exp_busy));
`ifdef MAC_SEQ_PERF_EN
    check("stall_count", 64'(stall_at_done), 64'(ws_tot + ds_tot));
`endif
    @(negedge Clk);
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
    if (cyc < 0) check("unused_stall_at_done", 64'(stall_at_done), 64'd0);
  endtask

  initial begin
    bus.wValid = 1'b0; bus.dValid = 1'b0; bus.resReady = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_outputs", all_outputs(), 64'd0);
    resetN = 1'b1;
    @(negedge Clk);
    check("idle_outputs", all_outputs(), 64'd0);

    run_job(2, 0, 0, -1, 0, -1, 0, -1, 0, -1);
    run_job(2, 0, 0, -1, 0, 1, 4, -1, 0, -1);
    run_job(3, 1, 1, -1, 0, -1, 0, 5, 10, -1);
    run_job(4, 1, 1, -1, 0, -1, 0, -1, 0, 7);
    run_job(2, 0, 0, -1, 0, -1, 0, -1, 0, -1);
    run_job(31, 2, 2, -1, 0, -1, 0, -1, 0, -1);
    run_job(4, 0, 0, 1, 3, 2, 5, -1, 0, -1);
    run_job(0, 1, 1, -1, 0, -1, 0, 0, 3, -1);
    repeat (3)
      run_job($urandom_range(0, 31), 2, 2, -1, 0, -1, 0,
              $urandom_range(0, 15), $urandom_range(0, 4), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
